// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and widths for the decode-stage bypass/interlock unit.
package hazard_forward_unit_pkg;

  localparam int unsigned REGADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH    = 32;

  typedef enum logic {
    SB_IDLE,
    SB_BUSY
  } sb_state_e;

  typedef enum logic [1:0] {
    FWD_REG,
    FWD_ALU,
    FWD_WB
  } fwd_sel_e;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Bundle of pipeline-side signals seen by hazard_forward_unit.
// master: pipeline driving operands/stage info; slave: the hazard unit.
interface hazard_forward_unit_if #(
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned AW     = hazard_forward_unit_pkg::REGADDR_WIDTH,
  parameter int unsigned DW     = hazard_forward_unit_pkg::DATA_WIDTH
);
  logic [NUM_RD*AW-1:0] opr_reg_addr;
  logic [NUM_RD-1:0]    opr_reg_used;
  logic [NUM_RD*DW-1:0] opr_reg_data;
  logic [AW-1:0]        id2ex_wb_addr;
  logic                 id2ex_is_load;
  logic [DW-1:0]        ex2mem_alu_result;
  logic [AW-1:0]        ex2mem_wb_reg_addr;
  logic                 ex2mem_wb_from_alu;
  logic                 ex2mem_is_load;
  logic                 regfile_write_en;
  logic [AW-1:0]        regfile_write_addr;
  logic [DW-1:0]        regfile_write_data;
  logic                 mdu_start;
  logic [AW-1:0]        mdu_dst_addr;
  logic [NUM_RD*DW-1:0] forward_data;
  logic                 stall;
  logic                 mdu_busy;
  logic [31:0]          stall_cycles;
  logic [31:0]          fwd_hits;

  modport master (
    output opr_reg_addr, opr_reg_used, opr_reg_data,
    output id2ex_wb_addr, id2ex_is_load,
    output ex2mem_alu_result, ex2mem_wb_reg_addr, ex2mem_wb_from_alu, ex2mem_is_load,
    output regfile_write_en, regfile_write_addr, regfile_write_data,
    output mdu_start, mdu_dst_addr,
    input  forward_data, stall, mdu_busy, stall_cycles, fwd_hits
  );

  modport slave (
    input  opr_reg_addr, opr_reg_used, opr_reg_data,
    input  id2ex_wb_addr, id2ex_is_load,
    input  ex2mem_alu_result, ex2mem_wb_reg_addr, ex2mem_wb_from_alu, ex2mem_is_load,
    input  regfile_write_en, regfile_write_addr, regfile_write_data,
    input  mdu_start, mdu_dst_addr,
    output forward_data, stall, mdu_busy, stall_cycles, fwd_hits
  );
endinterface

// File: rtl/hazard_forward_unit_fwd_mux_port.sv
// Per-read-port operand priority mux (ex2mem ALU > write-back > regfile)
// and load-use / pending-MDU hazard compare.
module fwd_mux_port import hazard_forward_unit_pkg::*; #(
  parameter int unsigned AW = REGADDR_WIDTH,
  parameter int unsigned DW = DATA_WIDTH
) (
  input  logic [AW-1:0] i_addr,
  input  logic          i_used,
  input  logic [DW-1:0] i_reg_data,
  input  logic [AW-1:0] i_ex2mem_addr,
  input  logic          i_ex2mem_from_alu,
  input  logic          i_ex2mem_is_load,
  input  logic [DW-1:0] i_ex2mem_result,
  input  logic          i_wb_en,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  input  logic [AW-1:0] i_id2ex_addr,
  input  logic          i_id2ex_is_load,
  input  logic          i_mdu_busy,
  input  logic [AW-1:0] i_pend_addr,
  output logic [DW-1:0] o_data,
  output fwd_sel_e      o_sel,
  output logic          o_hz
);
  logic w_nz;
  logic w_load_hz;
  logic w_mdu_hz;

  always_comb begin
    w_nz = (i_addr != '0);
    if (!w_nz)
      o_sel = FWD_REG;
    else if (i_ex2mem_from_alu && (i_addr == i_ex2mem_addr))
      o_sel = FWD_ALU;
    else if (i_wb_en && (i_addr == i_wb_addr))
      o_sel = FWD_WB;
    else
      o_sel = FWD_REG;

    case (o_sel)
      FWD_ALU: o_data = i_ex2mem_result;
      FWD_WB:  o_data = i_wb_data;
      default: o_data = i_reg_data;
    endcase

    w_load_hz = (i_id2ex_is_load && (i_addr == i_id2ex_addr)) ||
                (i_ex2mem_is_load && (i_addr == i_ex2mem_addr) && !i_ex2mem_from_alu);
    w_mdu_hz  = i_mdu_busy && (i_addr == i_pend_addr);
    o_hz      = i_used && w_nz && (w_load_hz || w_mdu_hz);
  end
endmodule

// File: rtl/hazard_forward_unit.sv
// Decode-stage operand bypass + load-use/MDU interlock with a single-entry
// MDU scoreboard. Optional perf counters enabled by macro HAZARD_PERF_EN.
module hazard_forward_unit #(
  parameter int unsigned NUM_RD        = 2,
  parameter int unsigned REGADDR_WIDTH = hazard_forward_unit_pkg::REGADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = hazard_forward_unit_pkg::DATA_WIDTH,
  parameter int unsigned MDU_LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_forward_unit_if.slave bus
);
  import hazard_forward_unit_pkg::*;

  localparam int unsigned CW = $clog2(MDU_LATENCY) + 1;

  sb_state_e                r_state;
  logic [REGADDR_WIDTH-1:0] r_pend_addr;
  logic [CW-1:0]            r_cnt;

  logic [NUM_RD-1:0] w_hz;
  fwd_sel_e          w_sel [NUM_RD];
  logic              w_mdu_busy;
  logic              w_struct_hz;
  logic              w_stall;
  logic              w_fwd_any;

  assign w_mdu_busy  = (r_state == SB_BUSY);
  assign w_struct_hz = bus.mdu_start && w_mdu_busy;
  assign w_stall     = !rst && ((|w_hz) || w_struct_hz);

  assign bus.stall    = w_stall;
  assign bus.mdu_busy = w_mdu_busy;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_port
    fwd_mux_port #(
      .AW (REGADDR_WIDTH),
      .DW (DATA_WIDTH)
    ) u_port (
      .i_addr            (bus.opr_reg_addr[g*REGADDR_WIDTH +: REGADDR_WIDTH]),
      .i_used            (bus.opr_reg_used[g]),
      .i_reg_data        (bus.opr_reg_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .i_ex2mem_addr     (bus.ex2mem_wb_reg_addr),
      .i_ex2mem_from_alu (bus.ex2mem_wb_from_alu),
      .i_ex2mem_is_load  (bus.ex2mem_is_load),
      .i_ex2mem_result   (bus.ex2mem_alu_result),
      .i_wb_en           (bus.regfile_write_en),
      .i_wb_addr         (bus.regfile_write_addr),
      .i_wb_data         (bus.regfile_write_data),
      .i_id2ex_addr      (bus.id2ex_wb_addr),
      .i_id2ex_is_load   (bus.id2ex_is_load),
      .i_mdu_busy        (w_mdu_busy),
      .i_pend_addr       (r_pend_addr),
      .o_data            (bus.forward_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_sel             (w_sel[g]),
      .o_hz              (w_hz[g])
    );
  end

  always_comb begin
    w_fwd_any = 1'b0;
    for (int unsigned i = 0; i < NUM_RD; i++)
      if (bus.opr_reg_used[i] && (w_sel[i] != FWD_REG))
        w_fwd_any = 1'b1;
  end

  // Writes to $0 are discarded by the regfile, so an MDU op targeting $0 is never tracked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SB_IDLE;
      r_pend_addr <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        SB_IDLE: begin
          if (bus.mdu_start && !w_stall && (bus.mdu_dst_addr != '0)) begin
            r_state     <= SB_BUSY;
            r_pend_addr <= bus.mdu_dst_addr;
            r_cnt       <= CW'(MDU_LATENCY - 1);
          end
        end
        SB_BUSY: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1))
            r_state <= SB_IDLE;
        end
        default: r_state <= SB_IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_fwd_hits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_fwd_hits     <= '0;
    end else begin
      if (w_stall && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_fwd_any && (r_fwd_hits != '1))
        r_fwd_hits <= r_fwd_hits + 1'b1;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
  assign bus.fwd_hits     = r_fwd_hits;
`else
  logic w_unused_fwd_any;
  assign w_unused_fwd_any = w_fwd_any;
  assign bus.stall_cycles = '0;
  assign bus.fwd_hits     = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed self-checking bench for hazard_forward_unit (NUM_RD=2, MDU_LATENCY=4).
module tb_hazard_forward_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [31:0] exp_sc;
  logic [31:0] exp_fh;

  hazard_forward_unit_if #(.NUM_RD(2), .AW(5), .DW(32)) bus ();

  hazard_forward_unit #(
    .NUM_RD        (2),
    .REGADDR_WIDTH (5),
    .DATA_WIDTH    (32),
    .MDU_LATENCY   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.opr_reg_addr       = '0;
    bus.opr_reg_used       = '0;
    bus.opr_reg_data       = {32'h1111_1111, 32'h2222_2222};
    bus.id2ex_wb_addr      = '0;
    bus.id2ex_is_load      = 1'b0;
    bus.ex2mem_alu_result  = '0;
    bus.ex2mem_wb_reg_addr = '0;
    bus.ex2mem_wb_from_alu = 1'b0;
    bus.ex2mem_is_load     = 1'b0;
    bus.regfile_write_en   = 1'b0;
    bus.regfile_write_addr = '0;
    bus.regfile_write_data = '0;
    bus.mdu_start          = 1'b0;
    bus.mdu_dst_addr       = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset, with a live load-use hazard on the inputs: stall must stay low.
    rst = 1'b1;
    idle();
    bus.id2ex_is_load = 1'b1;
    bus.id2ex_wb_addr = 5'd8;
    bus.opr_reg_addr  = {5'd0, 5'd8};
    bus.opr_reg_used  = 2'b01;
    tick(); #1;
    chk("rst_busy",  {31'd0, bus.mdu_busy}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall},    32'd0);
    chk("rst_sc",    bus.stall_cycles,      32'd0);
    chk("rst_fh",    bus.fwd_hits,          32'd0);
    idle();
    rst = 1'b0;
    tick();

    // ex2mem beats write-back on the same register.
    bus.opr_reg_addr       = {5'd0, 5'd5};
    bus.opr_reg_used       = 2'b11;
    bus.ex2mem_wb_reg_addr = 5'd5;
    bus.ex2mem_wb_from_alu = 1'b1;
    bus.ex2mem_alu_result  = 32'hDEAD_BEEF;
    bus.regfile_write_en   = 1'b1;
    bus.regfile_write_addr = 5'd5;
    bus.regfile_write_data = 32'h0000_1234;
    #1;
    chk("alu_prio",      bus.forward_data[31:0],   32'hDEAD_BEEF);
    chk("alu_prio_stall", {31'd0, bus.stall},      32'd0);

    // $0 is never forwarded.
    bus.ex2mem_wb_reg_addr = 5'd0;
    bus.ex2mem_alu_result  = 32'hFFFF_FFFF;
    #1;
    chk("zero_reg",  bus.forward_data[63:32], 32'h1111_1111);
    chk("wb_fwd",    bus.forward_data[31:0],  32'h0000_1234);

    // ex2mem load to the operand: stall, data from write-back rule.
    bus.ex2mem_wb_reg_addr = 5'd5;
    bus.ex2mem_wb_from_alu = 1'b0;
    bus.ex2mem_is_load     = 1'b1;
    #1;
    chk("ex2mem_ld_stall", {31'd0, bus.stall}, 32'd1);
    chk("ex2mem_ld_data",  bus.forward_data[31:0], 32'h0000_1234);
    idle();

    bus.opr_reg_addr = {5'd3, 5'd7};
    #1;
    chk("no_match", bus.forward_data[31:0], 32'h2222_2222);

    // Load-use in EX, used / unused.
    bus.id2ex_is_load = 1'b1;
    bus.id2ex_wb_addr = 5'd8;
    bus.opr_reg_addr  = {5'd0, 5'd8};
    bus.opr_reg_used  = 2'b01;
    #1;
    chk("ld_use_used",   {31'd0, bus.stall}, 32'd1);
    bus.opr_reg_used = 2'b00;
    #1;
    chk("ld_use_unused", {31'd0, bus.stall}, 32'd0);

    // Both ports hazarding: one stall.
    bus.opr_reg_addr       = {5'd6, 5'd8};
    bus.opr_reg_used       = 2'b11;
    bus.ex2mem_is_load     = 1'b1;
    bus.ex2mem_wb_reg_addr = 5'd6;
    #1;
    chk("two_port_stall", {31'd0, bus.stall}, 32'd1);

    // Load to $0 never stalls.
    idle();
    bus.id2ex_is_load = 1'b1;
    bus.id2ex_wb_addr = 5'd0;
    bus.opr_reg_addr  = {5'd0, 5'd0};
    bus.opr_reg_used  = 2'b11;
    #1;
    chk("ld_r0", {31'd0, bus.stall}, 32'd0);
    idle();
    tick();

    // MDU issue to $9, consumer on port0.
    bus.mdu_start    = 1'b1;
    bus.mdu_dst_addr = 5'd9;
    bus.opr_reg_addr = {5'd0, 5'd9};
    bus.opr_reg_used = 2'b01;
    #1;
    chk("mdu_issue_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    bus.mdu_start = 1'b0;
    #1;
    chk("mdu_c1_busy",  {31'd0, bus.mdu_busy}, 32'd1);
    chk("mdu_c1_stall", {31'd0, bus.stall},    32'd1);
    tick();
    // Second issue while busy: structural stall, not captured.
    bus.opr_reg_used = 2'b00;
    bus.mdu_start    = 1'b1;
    bus.mdu_dst_addr = 5'd12;
    #1;
    chk("mdu_c2_struct", {31'd0, bus.stall},    32'd1);
    chk("mdu_c2_busy",   {31'd0, bus.mdu_busy}, 32'd1);
    tick();
    bus.mdu_start    = 1'b0;
    bus.opr_reg_addr = {5'd12, 5'd9};
    bus.opr_reg_used = 2'b10;
    #1;
    chk("mdu_c3_pend_kept", {31'd0, bus.stall}, 32'd0);
    bus.opr_reg_used = 2'b01;
    #1;
    chk("mdu_c3_stall", {31'd0, bus.stall},    32'd1);
    chk("mdu_c3_busy",  {31'd0, bus.mdu_busy}, 32'd1);
    tick();
    bus.regfile_write_en   = 1'b1;
    bus.regfile_write_addr = 5'd9;
    bus.regfile_write_data = 32'h0000_CAFE;
    #1;
    chk("mdu_c4_busy",  {31'd0, bus.mdu_busy}, 32'd0);
    chk("mdu_c4_stall", {31'd0, bus.stall},    32'd0);
    chk("mdu_c4_data",  bus.forward_data[31:0], 32'h0000_CAFE);
    idle();
    tick();

    // Reset mid-BUSY abandons the result immediately.
    bus.mdu_start    = 1'b1;
    bus.mdu_dst_addr = 5'd10;
    tick();
    bus.mdu_start = 1'b0;
    #1;
    chk("mid_busy_pre", {31'd0, bus.mdu_busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_busy_rst", {31'd0, bus.mdu_busy}, 32'd0);
    tick();
    rst = 1'b0;
    bus.opr_reg_addr = {5'd0, 5'd10};
    bus.opr_reg_used = 2'b01;
    #1;
    chk("post_rst_stall", {31'd0, bus.stall}, 32'd0);
    idle();
    tick();

    // Perf phase: 3 stall cycles then 2 forwarding cycles.
    bus.id2ex_is_load = 1'b1;
    bus.id2ex_wb_addr = 5'd8;
    bus.opr_reg_addr  = {5'd0, 5'd8};
    bus.opr_reg_used  = 2'b01;
    tick(); tick(); tick();
    idle();
    bus.opr_reg_addr       = {5'd0, 5'd5};
    bus.opr_reg_used       = 2'b01;
    bus.ex2mem_wb_reg_addr = 5'd5;
    bus.ex2mem_wb_from_alu = 1'b1;
    tick(); tick();
    idle();
    tick();
`ifdef HAZARD_PERF_EN
    exp_sc = 32'd3;
    exp_fh = 32'd2;
`else
    exp_sc = 32'd0;
    exp_fh = 32'd0;
`endif
    chk("perf_stall_cycles", bus.stall_cycles, exp_sc);
    chk("perf_fwd_hits",     bus.fwd_hits,     exp_fh);

    // MDU op to $0 is not tracked.
    bus.mdu_start    = 1'b1;
    bus.mdu_dst_addr = 5'd0;
    tick();
    bus.mdu_start = 1'b0;
    #1;
    chk("mdu_r0_untracked", {31'd0, bus.mdu_busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
